avalon_io_bank: RTL and testbench

AVALON_IO_BANK -- requirements
Module: avalon_io_bank

---
 rtl/avalon_io_bank.sv | 91 +++++++++
 tb/tb_avalon_io_bank.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/avalon_io_bank.sv
// avalon_io_bank: Avalon-MM LED/switch/button bank with debounce and edge capture; optional IRQ via IO_BANK_IRQ_EN
module avalon_io_bank #(
  parameter int LED_W = 8,
  parameter int SW_W = 8,
  parameter int BTN_W = 3,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic             clk_clk,
  input  logic             reset_reset_n,
  input  logic [2:0]       avs_address,
  input  logic             avs_chipselect,
  input  logic             avs_read,
  input  logic             avs_write,
  input  logic [31:0]      avs_writedata,
  output logic [31:0]      avs_readdata,
  output logic             irq,
  output logic [LED_W-1:0] led_export,
  input  logic [SW_W-1:0]  sw_export,
  input  logic [BTN_W-1:0] btn_export
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  logic wr, rd;
  logic [SW_W-1:0] sw_s1, sw_s2;
  logic [BTN_W-1:0] btn_s1, btn_s2, btn_db, db_nxt, rise, edge_q, irq_mask, edge_clr;
  logic [CW-1:0] cnt [BTN_W];
  logic [CW-1:0] cnt_nxt [BTN_W];
  logic [31:0] rdata;
  logic unused_bits;
  assign wr = avs_chipselect & avs_write;
  assign rd = avs_chipselect & avs_read;
  assign unused_bits = ^avs_writedata;
  assign edge_clr = (wr && avs_address == 3'd3) ? avs_writedata[BTN_W-1:0] : '0;
  // per-button debounce: count consecutive differing cycles, accept the new level on the last one
  always_comb begin
    db_nxt = btn_db;
    for (int i = 0; i < BTN_W; i++) begin
      cnt_nxt[i] = '0;
      if (btn_s2[i] != btn_db[i]) begin
        if (cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) db_nxt[i] = btn_s2[i];
        else cnt_nxt[i] = cnt[i] + 1'b1;
      end
    end
    rise = db_nxt & ~btn_db;
  end
  // register read mux; unused upper bits are zero-extended
  always_comb
    rdata = avs_address == 3'd0 ? 32'(led_export) :
            avs_address == 3'd1 ? 32'(sw_s2) :
            avs_address == 3'd2 ? 32'(btn_db) :
            avs_address == 3'd3 ? 32'(edge_q) :
            avs_address == 3'd4 ? 32'(irq_mask) : 32'd0;
  // synchronisers, debounce state, LED, edge capture and read data
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      sw_s1 <= '0;
      sw_s2 <= '0;
      btn_s1 <= '0;
      btn_s2 <= '0;
      btn_db <= '0;
      cnt <= '{default: '0};
      edge_q <= '0;
      led_export <= '0;
      avs_readdata <= '0;
    end else begin
      sw_s1 <= sw_export;
      sw_s2 <= sw_s1;
      btn_s1 <= btn_export;
      btn_s2 <= btn_s1;
      btn_db <= db_nxt;
      cnt <= cnt_nxt;
      edge_q <= (edge_q & ~edge_clr) | rise;
      if (wr && avs_address == 3'd0) led_export <= avs_writedata[LED_W-1:0];
      if (rd) avs_readdata <= rdata;
    end
  end
`ifdef IO_BANK_IRQ_EN
  // interrupt mask register and registered level interrupt
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      irq_mask <= '0;
      irq <= 1'b0;
    end else begin
      if (wr && avs_address == 3'd4) irq_mask <= avs_writedata[BTN_W-1:0];
      irq <= |(edge_q & irq_mask);
    end
  end
`else
  assign irq_mask = '0;
  assign irq = 1'b0;
`endif
endmodule

// File: tb/tb_avalon_io_bank.sv
// tb_avalon_io_bank: directed bench with a cycle model of the IO bank register behaviour
module tb_avalon_io_bank;
  localparam int DEB = 4;
`ifdef IO_BANK_IRQ_EN
  localparam logic IRQ_EN = 1'b1;
`else
  localparam logic IRQ_EN = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset_reset_n;
  logic [2:0] avs_address;
  logic avs_chipselect, avs_read, avs_write;
  logic [31:0] avs_writedata, avs_readdata;
  logic irq;
  logic [7:0] led_export, sw_export;
  logic [2:0] btn_export;
  int errors = 0;
  int checks = 0;
  logic [31:0] q;
  always #5 clk = ~clk;
  avalon_io_bank #(.LED_W(8), .SW_W(8), .BTN_W(3), .DEBOUNCE_CYCLES(DEB)) dut (
    .clk_clk(clk), .reset_reset_n(reset_reset_n), .avs_address(avs_address),
    .avs_chipselect(avs_chipselect), .avs_read(avs_read), .avs_write(avs_write),
    .avs_writedata(avs_writedata), .avs_readdata(avs_readdata), .irq(irq),
    .led_export(led_export), .sw_export(sw_export), .btn_export(btn_export)
  );
  // behavioural model: state as seen by software, inputs delayed two samples
  logic [7:0] m_led, m_sw1, m_sw2;
  logic [2:0] m_b1, m_b2, m_db, m_db_n, m_edge, m_mask;
  logic m_irq;
  logic [31:0] m_rd;
  int m_run [3];
  int m_run_n [3];
  function automatic logic [31:0] m_read(input logic [2:0] a);
    case (a)
      3'd0: return {24'd0, m_led};
      3'd1: return {24'd0, m_sw2};
      3'd2: return {29'd0, m_db};
      3'd3: return {29'd0, m_edge};
      3'd4: return {29'd0, m_mask};
      default: return 32'd0;
    endcase
  endfunction
  always_comb begin
    m_db_n = m_db;
    for (int i = 0; i < 3; i++) begin
      m_run_n[i] = (m_b2[i] != m_db[i]) ? m_run[i] + 1 : 0;
      if (m_run_n[i] == DEB) begin
        m_db_n[i] = m_b2[i];
        m_run_n[i] = 0;
      end
    end
  end
  always @(posedge clk) begin
    if (!reset_reset_n) begin
      m_led <= 8'd0; m_sw1 <= 8'd0; m_sw2 <= 8'd0; m_b1 <= 3'd0; m_b2 <= 3'd0;
      m_db <= 3'd0; m_edge <= 3'd0; m_mask <= 3'd0; m_irq <= 1'b0; m_rd <= 32'd0;
      m_run <= '{default: 0};
    end else begin
      if (avs_chipselect && avs_write && avs_address == 3'd0) m_led <= avs_writedata[7:0];
      if (IRQ_EN && avs_chipselect && avs_write && avs_address == 3'd4) m_mask <= avs_writedata[2:0];
      if (avs_chipselect && avs_read) m_rd <= m_read(avs_address);
      m_edge <= (m_edge & ~((avs_chipselect && avs_write && avs_address == 3'd3) ? avs_writedata[2:0] : 3'd0)) | (m_db_n & ~m_db);
      m_irq <= IRQ_EN && ((m_edge & m_mask) != 3'd0);
      m_sw1 <= sw_export; m_sw2 <= m_sw1;
      m_b1 <= btn_export; m_b2 <= m_b1;
      m_db <= m_db_n;
      m_run <= m_run_n;
    end
  end
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
    check("led_model", 32'(led_export), 32'(m_led));
    check("irq_model", 32'(irq), 32'(m_irq));
    check("rdata_model", avs_readdata, m_rd);
  endtask
  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask
  task automatic wr_reg(input logic [2:0] a, input logic [31:0] d);
    avs_chipselect = 1'b1; avs_write = 1'b1; avs_address = a; avs_writedata = d;
    tick();
    avs_chipselect = 1'b0; avs_write = 1'b0;
  endtask
  task automatic rd_reg(input logic [2:0] a, output logic [31:0] d);
    avs_chipselect = 1'b1; avs_read = 1'b1; avs_address = a;
    tick();
    avs_chipselect = 1'b0; avs_read = 1'b0;
    d = avs_readdata;
  endtask
  initial begin
    reset_reset_n = 1'b0; avs_address = 3'd0; avs_chipselect = 1'b0; avs_read = 1'b0;
    avs_write = 1'b0; avs_writedata = 32'd0; sw_export = 8'd0; btn_export = 3'd0;
    ticks(2);
    reset_reset_n = 1'b1;
    check("rst_led", 32'(led_export), 32'd0);
    check("rst_rdata", avs_readdata, 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    wr_reg(3'd0, 32'hA5);
    check("led_write", 32'(led_export), 32'hA5);
    rd_reg(3'd0, q); check("led_read", q, 32'h0000_00A5);
    btn_export = 3'b001; ticks(2);
    btn_export = 3'b000; ticks(6);
    rd_reg(3'd2, q); check("glitch_ignored", q, 32'h0);
    btn_export = 3'b001; ticks(8);
    rd_reg(3'd2, q); check("btn_level", q, 32'h1);
    rd_reg(3'd3, q); check("edge_set", q, 32'h1);
    btn_export = 3'b000; ticks(8);
    rd_reg(3'd2, q); check("btn_release", q, 32'h0);
    rd_reg(3'd3, q); check("edge_kept_on_fall", q, 32'h1);
    btn_export = 3'b001; ticks(5);
    wr_reg(3'd3, 32'h1);
    rd_reg(3'd3, q); check("edge_set_wins", q, 32'h1);
    rd_reg(3'd2, q); check("btn_repress", q, 32'h1);
    wr_reg(3'd3, 32'h1);
    rd_reg(3'd3, q); check("edge_w1c", q, 32'h0);
    wr_reg(3'd4, 32'h2);
    rd_reg(3'd4, q); check("mask_read", q, IRQ_EN ? 32'h2 : 32'h0);
    btn_export = 3'b000; ticks(8);
    btn_export = 3'b001; ticks(8);
    check("irq_masked", 32'(irq), 32'd0);
    rd_reg(3'd3, q); check("edge_btn0", q, 32'h1);
    btn_export = 3'b011; ticks(8);
    check("irq_unmasked", 32'(irq), 32'(IRQ_EN));
    rd_reg(3'd3, q); check("edge_btn01", q, 32'h3);
    wr_reg(3'd3, 32'h2);
    check("irq_latency", 32'(irq), 32'(IRQ_EN));
    tick();
    check("irq_cleared", 32'(irq), 32'd0);
    rd_reg(3'd3, q); check("edge_partial_clr", q, 32'h1);
    wr_reg(3'd3, 32'h7); wr_reg(3'd4, 32'h0);
    btn_export = 3'b000; ticks(8);
    btn_export = 3'b100; ticks(4);
    reset_reset_n = 1'b0; tick(); reset_reset_n = 1'b1;
    check("rst2_led", 32'(led_export), 32'd0);
    ticks(4);
    rd_reg(3'd2, q); check("rst_discards_count", q, 32'h0);
    tick();
    rd_reg(3'd2, q); check("btn2_after_reset", q, 32'h4);
    sw_export = 8'h3C; ticks(2);
    rd_reg(3'd1, q); check("sw_read", q, 32'h3C);
    rd_reg(3'd6, q); check("reserved_read", q, 32'h0);
    wr_reg(3'd6, 32'hFF);
    rd_reg(3'd0, q); check("reserved_write_ignored", q, 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
